// File: rtl/ram_port_arbiter.sv
// Two-port round-robin front end for an asynchronous single-port RAM.
// Each accepted request becomes a SETUP / STROBE(xN) / HOLD cycle on the RAM pins.
module ram_port_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 32,
    parameter int STROBE_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  p0_valid,
    input  logic                  p0_we,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    output logic                  p0_ready,
    output logic                  p0_rsp_valid,
    output logic [DATA_WIDTH-1:0] p0_rdata,
    input  logic                  p1_valid,
    input  logic                  p1_we,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    output logic                  p1_ready,
    output logic                  p1_rsp_valid,
    output logic [DATA_WIDTH-1:0] p1_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    inout  wire  [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic                  mem_oe
);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD} state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [3:0]            r_cnt;
    logic                  r_rr_last;
    logic                  r_port;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata0;
    logic [DATA_WIDTH-1:0] r_rdata1;

    logic w_any;
    logic w_sel;
    logic w_grant;
    logic w_last;
    logic w_drive;

    // On contention the port that did not win last time is picked.
    assign w_any   = p0_valid | p1_valid;
    assign w_sel   = (p0_valid & p1_valid) ? ~r_rr_last : p1_valid;
    assign w_grant = (r_state == S_IDLE) & w_any;
    assign w_last  = (r_cnt == 4'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (w_any) w_state_next = S_SETUP;
            S_SETUP:  w_state_next = S_STROBE;
            S_STROBE: if (w_last) w_state_next = S_HOLD;
            S_HOLD:   w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        p0_ready     = 1'b0;
        p1_ready     = 1'b0;
        p0_rsp_valid = 1'b0;
        p1_rsp_valid = 1'b0;
        mem_cs       = 1'b0;
        mem_we       = 1'b0;
        mem_oe       = 1'b0;
        w_drive      = 1'b0;
        case (r_state)
            S_IDLE: begin
                p0_ready = w_any & ~w_sel;
                p1_ready = w_any & w_sel;
            end
            S_SETUP: begin
                mem_cs  = 1'b1;
                w_drive = r_we;
            end
            S_STROBE: begin
                mem_cs  = 1'b1;
                mem_we  = r_we;
                mem_oe  = ~r_we;
                w_drive = r_we;
            end
            S_HOLD: begin
                mem_cs       = 1'b1;
                w_drive      = r_we;
                p0_rsp_valid = ~r_we & ~r_port;
                p1_rsp_valid = ~r_we & r_port;
            end
            default: begin
                mem_cs = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= 4'd0;
            r_rr_last <= 1'b1;
            r_port    <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata0  <= '0;
            r_rdata1  <= '0;
        end else begin
            if (w_grant) begin
                r_port    <= w_sel;
                r_rr_last <= w_sel;
                r_we      <= w_sel ? p1_we    : p0_we;
                r_addr    <= w_sel ? p1_addr  : p0_addr;
                r_wdata   <= w_sel ? p1_wdata : p0_wdata;
            end
            if (r_state == S_SETUP) begin
                r_cnt <= 4'(STROBE_CYCLES - 1);
            end else if (r_state == S_STROBE && !w_last) begin
                r_cnt <= r_cnt - 4'd1;
            end
            // The RAM has had the full strobe time to settle; sample on its final edge.
            if (r_state == S_STROBE && w_last && !r_we) begin
                if (r_port) r_rdata1 <= mem_data;
                else        r_rdata0 <= mem_data;
            end
        end
    end

    assign mem_addr = r_addr;
    assign mem_data = w_drive ? r_wdata : {DATA_WIDTH{1'bz}};
    assign p0_rdata = r_rdata0;
    assign p1_rdata = r_rdata1;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Two arbiter instances (strobe length 1 and 4), each on its own RAM model,
// checked cycle by cycle against a transaction-timing reference model.
module tb_ram_port_arbiter;

    localparam int N0 = 1;
    localparam int N1 = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        p0_valid [2];
    logic        p0_we    [2];
    logic [31:0] p0_addr  [2];
    logic [31:0] p0_wdata [2];
    logic        p1_valid [2];
    logic        p1_we    [2];
    logic [31:0] p1_addr  [2];
    logic [31:0] p1_wdata [2];
    logic        p0_ready [2];
    logic        p1_ready [2];
    logic        p0_rsp_valid [2];
    logic        p1_rsp_valid [2];
    logic [31:0] p0_rdata [2];
    logic [31:0] p1_rdata [2];
    logic [31:0] mem_addr [2];
    logic        mem_cs   [2];
    logic        mem_we   [2];
    logic        mem_oe   [2];
    wire  [31:0] mon_data [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        wire  [31:0] mem_data;
        logic [31:0] ram [256];

        ram_port_arbiter #(
            .DATA_WIDTH(32), .ADDR_WIDTH(32), .STROBE_CYCLES(gi == 0 ? N0 : N1)
        ) u_dut (
            .clk(clk), .rst(rst),
            .p0_valid(p0_valid[gi]), .p0_we(p0_we[gi]), .p0_addr(p0_addr[gi]),
            .p0_wdata(p0_wdata[gi]), .p0_ready(p0_ready[gi]),
            .p0_rsp_valid(p0_rsp_valid[gi]), .p0_rdata(p0_rdata[gi]),
            .p1_valid(p1_valid[gi]), .p1_we(p1_we[gi]), .p1_addr(p1_addr[gi]),
            .p1_wdata(p1_wdata[gi]), .p1_ready(p1_ready[gi]),
            .p1_rsp_valid(p1_rsp_valid[gi]), .p1_rdata(p1_rdata[gi]),
            .mem_addr(mem_addr[gi]), .mem_data(mem_data),
            .mem_cs(mem_cs[gi]), .mem_we(mem_we[gi]), .mem_oe(mem_oe[gi])
        );

        // Asynchronous RAM: drives the bus only while output-enabled.
        assign mem_data = (mem_cs[gi] && mem_oe[gi] && !mem_we[gi]) ? ram[mem_addr[gi][7:0]] : 32'hzzzz_zzzz;
        always @(posedge clk) if (mem_cs[gi] && mem_we[gi]) ram[mem_addr[gi][7:0]] <= mem_data;
        assign mon_data[gi] = mem_data;
    end

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    logic        act [2];
    int          act_start [2];
    logic        a_we [2];
    int          a_port [2];
    logic [31:0] a_addr [2];
    logic [31:0] a_wdata [2];
    int          rr [2];
    int          first_grant [2];
    int          hs_count [2];
    logic [31:0] ref_mem [2][256];
    logic        ref_known [2][256];
    logic [31:0] exp_rdata [2][2];
    logic        exp_known [2][2];
    logic        req_v [2][2];
    logic        req_we [2][2];
    logic [31:0] req_addr [2][2];
    logic [31:0] req_data [2][2];
    logic        rnd_en = 1'b0;

    function automatic int strobe_n(input int d);
        return (d == 0) ? N0 : N1;
    endfunction

    task automatic chk(input int d, input string name, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL d%0d_%s cycle=%0d observed=%h expected=%h", d, name, cyc, obs, exp);
        end
    endtask

    task automatic model_reset(input int d);
        act[d] = 1'b0;
        rr[d] = 1;
        first_grant[d] = -1;
        for (int p = 0; p < 2; p++) begin
            exp_rdata[d][p] = 32'h0;
            exp_known[d][p] = 1'b1;
        end
    endtask

    task automatic check(input int d);
        int   n;
        int   ph;
        int   p;
        logic idle, er0, er1, ewe, eoe, ecs, rsp0, rsp1;
        n = strobe_n(d);
        if (rst) begin
            chk(d, "rst_cs", 32'(mem_cs[d]), 32'h0);
            chk(d, "rst_we", 32'(mem_we[d]), 32'h0);
            chk(d, "rst_oe", 32'(mem_oe[d]), 32'h0);
            chk(d, "rst_addr", mem_addr[d], 32'h0);
            chk(d, "rst_rsp", {30'h0, p1_rsp_valid[d], p0_rsp_valid[d]}, 32'h0);
            chk(d, "rst_ready", {30'h0, p1_ready[d], p0_ready[d]}, 32'h0);
            chk(d, "rst_rdata0", p0_rdata[d], 32'h0);
            chk(d, "rst_rdata1", p1_rdata[d], 32'h0);
            model_reset(d);
            return;
        end
        if (act[d] && (cyc - act_start[d] > n + 2)) act[d] = 1'b0;
        ph   = cyc - act_start[d];
        idle = !act[d];
        er0  = idle && p0_valid[d] && !(p1_valid[d] && rr[d] == 0);
        er1  = idle && p1_valid[d] && !(p0_valid[d] && rr[d] == 1);
        ecs  = act[d];
        ewe  = act[d] && a_we[d] && ph >= 2 && ph <= n + 1;
        eoe  = act[d] && !a_we[d] && ph >= 2 && ph <= n + 1;
        rsp0 = act[d] && !a_we[d] && ph == n + 2 && a_port[d] == 0;
        rsp1 = act[d] && !a_we[d] && ph == n + 2 && a_port[d] == 1;
        if (act[d] && !a_we[d] && ph == n + 2) begin
            exp_rdata[d][a_port[d]] = ref_mem[d][a_addr[d][7:0]];
            exp_known[d][a_port[d]] = ref_known[d][a_addr[d][7:0]];
        end
        chk(d, "p0_ready", 32'(p0_ready[d]), 32'(er0));
        chk(d, "p1_ready", 32'(p1_ready[d]), 32'(er1));
        chk(d, "mem_cs", 32'(mem_cs[d]), 32'(ecs));
        chk(d, "mem_we", 32'(mem_we[d]), 32'(ewe));
        chk(d, "mem_oe", 32'(mem_oe[d]), 32'(eoe));
        chk(d, "p0_rsp", 32'(p0_rsp_valid[d]), 32'(rsp0));
        chk(d, "p1_rsp", 32'(p1_rsp_valid[d]), 32'(rsp1));
        if (exp_known[d][0]) chk(d, "p0_rdata", p0_rdata[d], exp_rdata[d][0]);
        if (exp_known[d][1]) chk(d, "p1_rdata", p1_rdata[d], exp_rdata[d][1]);
        if (act[d]) begin
            chk(d, "mem_addr", mem_addr[d], a_addr[d]);
            if (a_we[d]) chk(d, "wr_bus", mon_data[d], a_wdata[d]);
            else if (eoe && ref_known[d][a_addr[d][7:0]])
                chk(d, "rd_bus", mon_data[d], ref_mem[d][a_addr[d][7:0]]);
        end
        p = er0 ? 0 : (er1 ? 1 : -1);
        if (p >= 0) begin
            act[d]       = 1'b1;
            act_start[d] = cyc;
            a_port[d]    = p;
            a_we[d]      = (p == 0) ? p0_we[d]    : p1_we[d];
            a_addr[d]    = (p == 0) ? p0_addr[d]  : p1_addr[d];
            a_wdata[d]   = (p == 0) ? p0_wdata[d] : p1_wdata[d];
            rr[d]        = p;
            if (first_grant[d] < 0) first_grant[d] = p;
            if (a_we[d]) begin
                ref_mem[d][a_addr[d][7:0]]   = a_wdata[d];
                ref_known[d][a_addr[d][7:0]] = 1'b1;
            end
            req_v[d][p] = 1'b0;
            hs_count[d]++;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check(0);
        check(1);
        cyc++;
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                if (rnd_en && !req_v[d][p] && $urandom_range(0, 1) == 1) begin
                    req_v[d][p]    = 1'b1;
                    req_we[d][p]   = 1'($urandom_range(0, 1));
                    req_addr[d][p] = 32'($urandom_range(0, 15));
                    req_data[d][p] = $urandom;
                end
            end
            p0_valid[d] = req_v[d][0]; p0_we[d] = req_we[d][0];
            p0_addr[d]  = req_addr[d][0]; p0_wdata[d] = req_data[d][0];
            p1_valid[d] = req_v[d][1]; p1_we[d] = req_we[d][1];
            p1_addr[d]  = req_addr[d][1]; p1_wdata[d] = req_data[d][1];
        end
    endtask

    task automatic issue(input int d, input int p, input logic we, input logic [31:0] addr, input logic [31:0] data);
        int waited;
        req_v[d][p] = 1'b1; req_we[d][p] = we; req_addr[d][p] = addr; req_data[d][p] = data;
        waited = 0;
        while (req_v[d][p] && waited < 60) begin
            tick();
            waited++;
        end
        vectors++;
        assert (!req_v[d][p]) else begin
            miscompares++;
            $error("FAIL d%0d_accept_timeout port=%0d observed=pending required=accepted", d, p);
        end
    endtask

    initial begin
        int base0, base1, guard;
        for (int d = 0; d < 2; d++) begin
            hs_count[d] = 0;
            model_reset(d);
            for (int a = 0; a < 256; a++) begin
                ref_mem[d][a] = 32'h0;
                ref_known[d][a] = 1'b0;
            end
            for (int p = 0; p < 2; p++) begin
                req_v[d][p] = 1'b0; req_we[d][p] = 1'b0;
                req_addr[d][p] = 32'h0; req_data[d][p] = 32'h0;
            end
            p0_valid[d] = 1'b0; p0_we[d] = 1'b0; p0_addr[d] = 32'h0; p0_wdata[d] = 32'h0;
            p1_valid[d] = 1'b0; p1_we[d] = 1'b0; p1_addr[d] = 32'h0; p1_wdata[d] = 32'h0;
        end

        repeat (3) tick();
        rst = 1'b0;
        repeat (20) tick();

        issue(0, 0, 1'b1, 32'h10, 32'hDEADBEEF);
        issue(0, 0, 1'b0, 32'h10, 32'h0);
        repeat (5) tick();
        issue(1, 1, 1'b1, 32'h20, 32'h12345678);
        issue(1, 1, 1'b0, 32'h20, 32'h0);
        repeat (8) tick();

        issue(0, 0, 1'b1, 32'h1, 32'hA5A5_0001);
        issue(0, 1, 1'b1, 32'h2, 32'h5A5A_0002);
        for (int k = 0; k < 24; k++) begin
            for (int p = 0; p < 2; p++) begin
                if (!req_v[0][p]) begin
                    req_v[0][p] = 1'b1; req_we[0][p] = 1'b0;
                    req_addr[0][p] = 32'(p + 1); req_data[0][p] = 32'h0;
                end
            end
            tick();
        end
        req_v[0][0] = 1'b0;
        req_v[0][1] = 1'b0;
        repeat (6) tick();

        base0 = hs_count[0];
        base1 = hs_count[1];
        rnd_en = 1'b1;
        guard = 0;
        while ((hs_count[0] < base0 + 100 || hs_count[1] < base1 + 100) && guard < 5000) begin
            tick();
            guard++;
        end
        vectors++;
        assert (guard < 5000) else begin
            miscompares++;
            $error("FAIL random_progress observed=%0d/%0d transactions required=100", hs_count[0] - base0, hs_count[1] - base1);
        end
        rnd_en = 1'b0;
        repeat (30) tick();

        issue(0, 0, 1'b1, 32'hFF, 32'hCAFE_F00D);
        tick();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                req_v[d][p] = 1'b1; req_we[d][p] = 1'b0;
                req_addr[d][p] = 32'(p + 1); req_data[d][p] = 32'h0;
            end
        end
        repeat (20) tick();
        chk(0, "first_grant_after_rst", 32'(first_grant[0]), 32'h0);
        chk(1, "first_grant_after_rst", 32'(first_grant[1]), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
